// File: rtl/voice_sched.sv
// Polyphonic voice scheduler: allocates voices to note events and time-multiplexes
// them through the shared accumulator/LUT datapath, summing the returned waveforms.
module voice_sched #(
    parameter int NUM_BITS     = 32,
    parameter int NUM_CHANNELS = 16,
    parameter int WIDTH        = 18,
    parameter int NOTE_BITS    = 7,
    parameter int LAT          = 2
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     note_valid,
    output logic                                     note_ready,
    input  logic                                     note_on,
    input  logic [NOTE_BITS-1:0]                     note_num,
    input  logic [NUM_BITS-1:0]                      note_word,
    input  logic                                     sample_tick,
    output logic [NUM_CHANNELS-1:0]                  acc_en,
    output logic [NUM_CHANNELS-1:0]                  acc_clr,
    output logic [NUM_CHANNELS-1:0]                  curr_note,
    output logic [NUM_BITS-1:0]                      tuning_word,
    input  logic [WIDTH-1:0]                         wave_in,
    output logic [WIDTH+$clog2(NUM_CHANNELS)-1:0]    mix_out,
    output logic                                     mix_valid,
    output logic [NUM_CHANNELS-1:0]                  voices_busy,
    output logic                                     drop,
    output logic                                     overrun
);
    localparam int CH_W  = $clog2(NUM_CHANNELS);
    localparam int LAT_W = $clog2(LAT + 1);
    localparam int CNT_W = (CH_W > LAT_W) ? CH_W : LAT_W;
    localparam int MIX_W = WIDTH + CH_W;

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;
    state_t state, state_nxt;

    logic [CNT_W-1:0]     cnt;
    logic [CH_W-1:0]      ch_idx;
    logic                 last_scan, last_drain;
    logic [NUM_CHANNELS-1:0] busy;
    logic [NOTE_BITS-1:0] note_tab [NUM_CHANNELS];
    logic [NUM_BITS-1:0]  word_tab [NUM_CHANNELS];
    logic                 accept;
    logic                 match_hit, free_hit;
    logic [CH_W-1:0]      match_idx, free_idx;
    logic [LAT-1:0]       tag_pipe;
    logic                 scan_tag;
    logic signed [MIX_W-1:0] acc, wave_add;

    assign ch_idx      = cnt[CH_W-1:0];
    assign last_scan   = (cnt == CNT_W'(NUM_CHANNELS - 1));
    assign last_drain  = (cnt == CNT_W'(LAT - 1));
    assign note_ready  = (state == IDLE);
    assign accept      = note_valid && (state == IDLE);
    assign voices_busy = busy;
    assign scan_tag    = (state == SCAN) && busy[ch_idx];
    assign wave_add    = tag_pipe[LAT-1] ? {{CH_W{wave_in[WIDTH-1]}}, wave_in} : '0;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (sample_tick) state_nxt = SCAN;
            SCAN:    if (last_scan)   state_nxt = DRAIN;
            DRAIN:   if (last_drain)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // One counter serves both the channel scan and the drain wait.
    always_ff @(posedge clk) begin
        if (rst || state == IDLE || state != state_nxt) cnt <= '0;
        else                                           cnt <= cnt + 1'b1;
    end

    always_comb begin
        match_hit = 1'b0;
        match_idx = '0;
        free_hit  = 1'b0;
        free_idx  = '0;
        for (int unsigned v = 0; v < NUM_CHANNELS; v++) begin
            if (!match_hit && busy[v] && note_tab[v] == note_num) begin
                match_hit = 1'b1;
                match_idx = CH_W'(v);
            end
            if (!free_hit && !busy[v]) begin
                free_hit = 1'b1;
                free_idx = CH_W'(v);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy    <= '0;
            acc_clr <= '0;
            drop    <= 1'b0;
            for (int unsigned v = 0; v < NUM_CHANNELS; v++) begin
                note_tab[v] <= '0;
                word_tab[v] <= '0;
            end
        end else begin
            acc_clr <= '0;
            drop    <= 1'b0;
            if (accept) begin
                if (note_on) begin
                    if (match_hit) begin
                        word_tab[match_idx] <= note_word;
                        acc_clr             <= NUM_CHANNELS'(1) << match_idx;
                    end else if (free_hit) begin
                        busy[free_idx]     <= 1'b1;
                        note_tab[free_idx] <= note_num;
                        word_tab[free_idx] <= note_word;
                        acc_clr            <= NUM_CHANNELS'(1) << free_idx;
                    end else begin
                        drop <= 1'b1;
                    end
                end else if (match_hit) begin
                    busy[match_idx] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        curr_note   = '0;
        acc_en      = '0;
        tuning_word = '0;
        if (state == SCAN) begin
            curr_note   = NUM_CHANNELS'(1) << ch_idx;
            acc_en      = busy[ch_idx] ? curr_note : '0;
            tuning_word = word_tab[ch_idx];
        end
    end

    // The busy tag travels alongside the datapath so each returning sample is
    // accepted only if its voice was active when it was selected.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_pipe  <= '0;
            acc       <= '0;
            mix_out   <= '0;
            mix_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            mix_valid <= 1'b0;
            overrun   <= sample_tick && (state != IDLE);
            tag_pipe  <= (tag_pipe << 1) | LAT'(scan_tag);
            if (state == IDLE && state_nxt == SCAN) acc <= '0;
            else                                    acc <= acc + wave_add;
            if (state == DRAIN && last_drain) begin
                mix_out   <= acc + wave_add;
                mix_valid <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_voice_sched.sv
// Directed bench for voice_sched: allocation, full table, mixing, signed sums,
// tick/event collisions and reset during a scan.
module tb_voice_sched;
    logic        clk = 1'b0;
    logic        rst, note_valid, note_ready, note_on, sample_tick;
    logic [6:0]  note_num;
    logic [31:0] note_word, tuning_word;
    logic [15:0] acc_en, acc_clr, curr_note, voices_busy;
    logic [17:0] wave_in;
    logic [21:0] mix_out;
    logic        mix_valid, drop, overrun;

    logic [17:0] wave_val [16];
    logic [15:0] sel_d1 = '0, sel_d2 = '0;
    int n_pass = 0, n_total = 0;

    voice_sched #(.NUM_BITS(32), .NUM_CHANNELS(16), .WIDTH(18), .NOTE_BITS(7), .LAT(2)) dut (
        .clk(clk), .rst(rst), .note_valid(note_valid), .note_ready(note_ready),
        .note_on(note_on), .note_num(note_num), .note_word(note_word),
        .sample_tick(sample_tick), .acc_en(acc_en), .acc_clr(acc_clr),
        .curr_note(curr_note), .tuning_word(tuning_word), .wave_in(wave_in),
        .mix_out(mix_out), .mix_valid(mix_valid), .voices_busy(voices_busy),
        .drop(drop), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Note generator stand-in: returns the selected channel's sample two cycles later.
    always @(posedge clk) begin
        sel_d1 <= curr_note;
        sel_d2 <= sel_d1;
    end

    always_comb begin
        wave_in = 18'h15555;
        for (int i = 0; i < 16; i++)
            if (sel_d2[i]) wave_in = wave_val[i];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic on, input int num, input logic [31:0] word);
        note_valid = 1'b1;
        note_on    = on;
        note_num   = 7'(num);
        note_word  = word;
        @(posedge clk); #1;
        note_valid = 1'b0;
    endtask

    task automatic set_waves_default();
        for (int i = 0; i < 16; i++) wave_val[i] = 18'(100 * (i + 1));
    endtask

    task automatic run_pass(input int ovr_k, output int lat, output logic [21:0] mv,
                            output int pulses, output logic [15:0] en_or,
                            output logic [31:0] tw3, output logic [15:0] first_sel,
                            output logic ovr_seen, output logic rdy_scan);
        lat = -1; mv = '0; pulses = 0; en_or = '0; tw3 = '0;
        first_sel = '0; ovr_seen = 1'b0; rdy_scan = 1'b1;
        sample_tick = 1'b1;
        @(posedge clk); #1;
        sample_tick = 1'b0;
        note_valid  = 1'b0;
        for (int k = 1; k <= 25; k++) begin
            en_or |= acc_en;
            if (curr_note == 16'h0008) tw3 = tuning_word;
            if (k == 1) first_sel = curr_note;
            if (k == 3) rdy_scan = note_ready;
            sample_tick = (k == ovr_k);
            @(posedge clk); #1;
            sample_tick = 1'b0;
            if (overrun) ovr_seen = 1'b1;
            if (mix_valid) begin
                pulses++;
                if (lat < 0) begin
                    lat = k;
                    mv  = mix_out;
                end
            end
        end
    endtask

    int          lat, pulses;
    logic [21:0] mv;
    logic [15:0] en_or, first_sel;
    logic [31:0] tw3;
    logic        ovr_seen, rdy_scan;

    initial begin
        rst = 1'b1; note_valid = 1'b0; note_on = 1'b0; note_num = '0;
        note_word = '0; sample_tick = 1'b0;
        set_waves_default();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_ready", 64'(note_ready), 64'd1);
        check("rst_busy", 64'(voices_busy), 64'd0);
        check("rst_vec", 64'({acc_en, acc_clr, curr_note}), 64'd0);
        check("rst_tw", 64'(tuning_word), 64'd0);
        check("rst_flags", 64'({mix_out, mix_valid, drop, overrun}), 64'd0);

        // Allocation and retrigger
        send(1'b1, 60, 32'h01000000);
        check("alloc0_busy", 64'(voices_busy), 64'h0001);
        check("alloc0_clr", 64'(acc_clr), 64'h0001);
        @(posedge clk); #1;
        check("alloc0_clr_end", 64'(acc_clr), 64'h0000);
        send(1'b1, 64, 32'h01400000);
        check("alloc1_busy", 64'(voices_busy), 64'h0003);
        check("alloc1_clr", 64'(acc_clr), 64'h0002);
        send(1'b1, 60, 32'h01100000);
        check("retrig_clr", 64'(acc_clr), 64'h0001);
        check("retrig_busy", 64'(voices_busy), 64'h0003);

        // Fill the table, then overflow it
        for (int n = 70; n <= 83; n++) send(1'b1, n, 32'(n) << 16);
        check("full_busy", 64'(voices_busy), 64'hFFFF);
        send(1'b1, 90, 32'h00990000);
        check("drop_pulse", 64'(drop), 64'd1);
        check("drop_busy", 64'(voices_busy), 64'hFFFF);
        check("drop_noclr", 64'(acc_clr), 64'h0000);
        @(posedge clk); #1;
        check("drop_end", 64'(drop), 64'd0);
        send(1'b0, 99, 32'h0);
        check("off_nomatch", 64'(voices_busy), 64'hFFFF);
        send(1'b0, 60, 32'h0);
        check("off_60", 64'(voices_busy), 64'hFFFE);

        // Mix with voices 0 and 3 active
        send(1'b0, 64, 32'h0);
        for (int n = 70; n <= 83; n++) if (n != 71) send(1'b0, n, 32'h0);
        send(1'b1, 60, 32'h01000000);
        check("mix_busy", 64'(voices_busy), 64'h0009);
        run_pass(0, lat, mv, pulses, en_or, tw3, first_sel, ovr_seen, rdy_scan);
        check("mix_latency", 64'(lat), 64'd18);
        check("mix_sum", 64'(mv), 64'd500);
        check("mix_pulses", 64'(pulses), 64'd1);
        check("mix_acc_en", 64'(en_or), 64'h0009);
        check("mix_tw3", 64'(tw3), 64'h00470000);
        check("mix_first_sel", 64'(first_sel), 64'h0001);
        check("mix_no_overrun", 64'(ovr_seen), 64'd0);
        check("mix_idle_after", 64'({note_ready, curr_note}), 64'h10000);

        // Signed extremes on voices 1 and 2
        send(1'b0, 60, 32'h0);
        send(1'b0, 71, 32'h0);
        send(1'b1, 61, 32'h003D0000);
        send(1'b1, 62, 32'h003E0000);
        send(1'b1, 63, 32'h003F0000);
        send(1'b0, 61, 32'h0);
        check("signed_busy", 64'(voices_busy), 64'h0006);
        wave_val[1] = 18'h20000;
        wave_val[2] = 18'h1FFFF;
        run_pass(0, lat, mv, pulses, en_or, tw3, first_sel, ovr_seen, rdy_scan);
        check("signed_sum", 64'(mv), 64'h3FFFFF);
        check("signed_acc_en", 64'(en_or), 64'h0006);

        // All voices at the most negative sample
        for (int n = 100; n <= 113; n++) send(1'b1, n, 32'(n) << 16);
        check("neg_busy", 64'(voices_busy), 64'hFFFF);
        for (int i = 0; i < 16; i++) wave_val[i] = 18'h20000;
        run_pass(0, lat, mv, pulses, en_or, tw3, first_sel, ovr_seen, rdy_scan);
        check("neg_sum", 64'(mv), 64'h200000);
        check("neg_latency", 64'(lat), 64'd18);

        // No busy voices: zero mix still pulses
        set_waves_default();
        send(1'b0, 62, 32'h0);
        send(1'b0, 63, 32'h0);
        for (int n = 100; n <= 113; n++) send(1'b0, n, 32'h0);
        check("empty_busy", 64'(voices_busy), 64'h0000);
        run_pass(0, lat, mv, pulses, en_or, tw3, first_sel, ovr_seen, rdy_scan);
        check("empty_sum", 64'(mv), 64'd0);
        check("empty_pulses", 64'(pulses), 64'd1);

        // Tick and note-on together, plus a tick during SCAN
        note_valid = 1'b1; note_on = 1'b1; note_num = 7'd50; note_word = 32'h00320000;
        run_pass(5, lat, mv, pulses, en_or, tw3, first_sel, ovr_seen, rdy_scan);
        check("coll_busy", 64'(voices_busy), 64'h0001);
        check("coll_sum", 64'(mv), 64'd100);
        check("coll_pulses", 64'(pulses), 64'd1);
        check("coll_overrun", 64'(ovr_seen), 64'd1);
        check("coll_ready_scan", 64'(rdy_scan), 64'd0);
        check("coll_latency", 64'(lat), 64'd18);

        // Reset in the middle of a scan
        sample_tick = 1'b1;
        @(posedge clk); #1;
        sample_tick = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("midrst_scanning", 64'(note_ready), 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_busy", 64'(voices_busy), 64'h0000);
        check("midrst_idle", 64'({note_ready, curr_note, acc_en}), 64'h100000000);
        pulses = 0;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk); #1;
            if (mix_valid) pulses++;
        end
        check("midrst_no_mix", 64'(pulses), 64'd0);
        check("midrst_ready", 64'(note_ready), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
